// File: rtl/pmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// pmem_arb_pkg
// Shared definitions for the physical-memory arbiter: the arbiter FSM state
// encoding, the fixed client slot numbers of the L1 caches and a helper that
// sizes client-index registers.
// ----------------------------------------------------------------------------
package pmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int ICACHE_IDX = 0;
  localparam int DCACHE_IDX = 1;

  // Width of a client index; never below one bit so a single-client build
  // still has a legal register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmem_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Purely combinational winner selection for the memory arbiter.
//   i_req        : request vector, one bit per client
//   i_last_idx   : index of the most recently completed client
//   i_fixed_prio : 1 = lowest requesting index wins, 0 = round-robin
//   o_winner     : selected client index (0 when nothing requests)
//   o_valid      : at least one client requests
// ----------------------------------------------------------------------------
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last_idx,
  input  logic             i_fixed_prio,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_valid
);

  int w_dist;
  int w_best;

  // Each client gets a distance from the search start; the requesting client
  // with the smallest distance wins. Round-robin starts the search one slot
  // after i_last_idx (so last_idx itself is farthest), fixed priority starts
  // at index 0.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_dist   = 0;
    w_best   = 0;
    for (int i = 0; i < N; i++) begin
      if (i_fixed_prio) begin
        w_dist = i;
      end else begin
        w_dist = (i + N - 1 - int'(i_last_idx)) % N;
      end
      if (i_req[i] && (!o_valid || (w_dist < w_best))) begin
        o_valid  = 1'b1;
        o_winner = IDX_W'(i);
        w_best   = w_dist;
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// ----------------------------------------------------------------------------
// pmem_arbiter
// Arbitrates NUM_CLIENTS line-granular cache clients (0 = icache, 1 = dcache,
// others = extra clients) onto a single L2 / physical-memory port. A grant is
// registered in IDLE and held for the whole transaction until m_resp.
//   clk, rst_n          : clock, asynchronous active-low reset
//   c_read / c_write    : per-client level requests, held until c_resp
//   c_address / c_wdata : per-client address / write line, client i at slot i
//   c_rdata             : read line, broadcast; qualified by c_resp
//   c_resp              : one-hot completion pulse to the granted client
//   m_read / m_write    : downstream request from the granted client
//   m_address / m_wdata : downstream address / write line
//   m_rdata / m_resp    : downstream read line / single-cycle completion
// ----------------------------------------------------------------------------
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int FIXED_PRIO  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        c_read,
  input  logic [NUM_CLIENTS-1:0]        c_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] c_address,
  input  logic [NUM_CLIENTS*LINE_W-1:0] c_wdata,
  output logic [LINE_W-1:0]             c_rdata,
  output logic [NUM_CLIENTS-1:0]        c_resp,
  output logic                          m_read,
  output logic                          m_write,
  output logic [ADDR_W-1:0]             m_address,
  output logic [LINE_W-1:0]             m_wdata,
  input  logic [LINE_W-1:0]             m_rdata,
  input  logic                          m_resp
);

  localparam int IDX_W = idx_width(NUM_CLIENTS);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_grant_idx;
  logic [IDX_W-1:0]       r_last_idx;

  logic [NUM_CLIENTS-1:0] w_req;
  logic [IDX_W-1:0]       w_winner;
  logic                   w_winner_vld;
  logic                   w_busy;
  logic                   w_done;

  logic                   w_sel_read;
  logic                   w_sel_write;
  logic [ADDR_W-1:0]      w_sel_addr;
  logic [LINE_W-1:0]      w_sel_wdata;

  assign w_req  = c_read | c_write;
  assign w_busy = (r_state == BUSY);
  assign w_done = w_busy & m_resp;

  rr_picker #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req        (w_req),
    .i_last_idx   (r_last_idx),
    .i_fixed_prio (FIXED_PRIO != 0),
    .o_winner     (w_winner),
    .o_valid      (w_winner_vld)
  );

  // State register, grant and round-robin pointer. Reset leaves last_idx on
  // the highest slot so client 0 is the first round-robin winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_last_idx  <= IDX_W'(NUM_CLIENTS - 1);
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_winner_vld) begin
        r_grant_idx <= w_winner;
      end
      if (w_done) begin
        r_last_idx <= r_grant_idx;
      end
    end
  end

  // Next-state logic. A stray m_resp in IDLE has no effect.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_winner_vld) w_state_nxt = BUSY;
      BUSY:    if (m_resp)       w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select the granted client's live request fields. The client holds them
  // stable for the transaction, so no copy is registered.
  always_comb begin
    w_sel_read  = 1'b0;
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (r_grant_idx == IDX_W'(i)) begin
        w_sel_read  = c_read[i];
        w_sel_write = c_write[i];
        w_sel_addr  = c_address[i*ADDR_W +: ADDR_W];
        w_sel_wdata = c_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  // Outputs: downstream port only driven while BUSY; completion is passed
  // straight through to the granted client in the m_resp cycle.
  always_comb begin
    m_read    = 1'b0;
    m_write   = 1'b0;
    m_address = '0;
    m_wdata   = '0;
    c_resp    = '0;
    if (w_busy) begin
      m_read    = w_sel_read;
      m_write   = w_sel_write;
      m_address = w_sel_addr;
      m_wdata   = w_sel_wdata;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        c_resp[i] = m_resp && (r_grant_idx == IDX_W'(i));
      end
    end
  end

  // Read data is broadcast; it is forced to zero only while reset is held.
  assign c_rdata = rst_n ? m_rdata : '0;

  // The granted client must keep its request up until its completion.
  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == BUSY) |-> w_req[r_grant_idx]);

  // A client may issue a read or a write, never both at once.
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
    ((c_read & c_write) == '0));

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

  typedef struct {
    int           client;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t a_q[$];
  exp_t f_q[$];
  exp_t q_q[$];
  int a_done = 0;
  int f_done = 0;
  int q_done = 0;

  localparam logic [255:0] W0 = {32{8'h11}};
  localparam logic [255:0] W1 = {32{8'h22}};
  localparam logic [255:0] WA5 = {32{8'hA5}};

  // ---------------- round-robin, 2 clients ----------------
  logic [1:0]   a_read = '0, a_write = '0, a_cresp;
  logic [63:0]  a_addr = '0;
  logic [511:0] a_wdata = '0;
  logic [255:0] a_crdata, a_mwdata, a_mrdata = '0;
  logic         a_mread, a_mwrite, a_mresp = 1'b0;
  logic [31:0]  a_maddr;
  int           a_lat = 3;
  int           a_cnt = 0;

  pmem_arbiter #(.NUM_CLIENTS(2), .ADDR_W(32), .LINE_W(256), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .c_read(a_read), .c_write(a_write),
    .c_address(a_addr), .c_wdata(a_wdata), .c_rdata(a_crdata), .c_resp(a_cresp),
    .m_read(a_mread), .m_write(a_mwrite), .m_address(a_maddr), .m_wdata(a_mwdata),
    .m_rdata(a_mrdata), .m_resp(a_mresp));

  // ---------------- fixed priority, 2 clients ----------------
  logic [1:0]   f_read = '0, f_write = '0, f_cresp;
  logic [63:0]  f_addr = '0;
  logic [511:0] f_wdata = '0;
  logic [255:0] f_crdata, f_mwdata, f_mrdata = '0;
  logic         f_mread, f_mwrite, f_mresp = 1'b0;
  logic [31:0]  f_maddr;
  int           f_cnt = 0;

  pmem_arbiter #(.NUM_CLIENTS(2), .ADDR_W(32), .LINE_W(256), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .c_read(f_read), .c_write(f_write),
    .c_address(f_addr), .c_wdata(f_wdata), .c_rdata(f_crdata), .c_resp(f_cresp),
    .m_read(f_mread), .m_write(f_mwrite), .m_address(f_maddr), .m_wdata(f_mwdata),
    .m_rdata(f_mrdata), .m_resp(f_mresp));

  // ---------------- round-robin, 4 clients ----------------
  logic [3:0]    q_read = '0, q_write = '0, q_cresp;
  logic [127:0]  q_addr = '0;
  logic [1023:0] q_wdata = '0;
  logic [255:0]  q_crdata, q_mwdata, q_mrdata = '0;
  logic          q_mread, q_mwrite, q_mresp;
  logic          q_resp_auto = 1'b0, q_stray = 1'b0, q_auto = 1'b0;
  logic [31:0]   q_maddr;
  int            q_cnt = 0;

  assign q_mresp = q_resp_auto | q_stray;

  pmem_arbiter #(.NUM_CLIENTS(4), .ADDR_W(32), .LINE_W(256), .FIXED_PRIO(0)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .c_read(q_read), .c_write(q_write),
    .c_address(q_addr), .c_wdata(q_wdata), .c_rdata(q_crdata), .c_resp(q_cresp),
    .m_read(q_mread), .m_write(q_mwrite), .m_address(q_maddr), .m_wdata(q_mwdata),
    .m_rdata(q_mrdata), .m_resp(q_mresp));

  function automatic logic [255:0] pat(input logic [31:0] ad);
    return {8{ad ^ 32'hC0DE_0000}};
  endfunction

  function automatic exp_t mk(input int c, input bit wr, input logic [31:0] ad,
                              input logic [255:0] wd);
    exp_t e;
    e.client = c; e.wr = wr; e.addr = ad; e.wdata = wd;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- memory responders ----------------
  always begin
    @(posedge clk); #1;
    if (a_mresp) a_mresp = 1'b0;
    else if (a_mread || a_mwrite) begin
      if (a_cnt >= a_lat - 1) begin a_mresp = 1'b1; a_mrdata = pat(a_maddr); a_cnt = 0; end
      else a_cnt++;
    end else a_cnt = 0;
  end

  always begin
    @(posedge clk); #1;
    if (f_mresp) f_mresp = 1'b0;
    else if (f_mread || f_mwrite) begin
      if (f_cnt >= 2) begin f_mresp = 1'b1; f_mrdata = pat(f_maddr); f_cnt = 0; end
      else f_cnt++;
    end else f_cnt = 0;
  end

  always begin
    @(posedge clk); #1;
    if (q_resp_auto) q_resp_auto = 1'b0;
    else if (q_auto && (q_mread || q_mwrite)) begin
      if (q_cnt >= 1) begin q_resp_auto = 1'b1; q_mrdata = pat(q_maddr); q_cnt = 0; end
      else q_cnt++;
    end else q_cnt = 0;
  end

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin : mon_a
    exp_t e;
    logic [255:0] oh;
    if (a_cresp != '0) begin
      if (a_q.size() == 0) chk("a_unexpected_resp", 256'(a_cresp), 256'd0);
      else begin
        e = a_q.pop_front();
        oh = '0; oh[e.client] = 1'b1;
        chk("a_resp", 256'(a_cresp), oh);
        chk("a_maddr", 256'(a_maddr), 256'(e.addr));
        chk("a_mwrite", 256'(a_mwrite), 256'(e.wr));
        chk("a_mread", 256'(a_mread), 256'(!e.wr));
        chk("a_mwdata", a_mwdata, e.wdata);
        chk("a_rdata", a_crdata, pat(e.addr));
        a_done++;
      end
    end
  end

  always @(negedge clk) begin : mon_f
    exp_t e;
    logic [255:0] oh;
    if (f_cresp != '0) begin
      if (f_q.size() == 0) chk("f_unexpected_resp", 256'(f_cresp), 256'd0);
      else begin
        e = f_q.pop_front();
        oh = '0; oh[e.client] = 1'b1;
        chk("f_resp", 256'(f_cresp), oh);
        chk("f_maddr", 256'(f_maddr), 256'(e.addr));
        chk("f_rdata", f_crdata, pat(e.addr));
        f_done++;
      end
    end
  end

  always @(negedge clk) begin : mon_q
    exp_t e;
    logic [255:0] oh;
    if (q_cresp != '0) begin
      if (q_q.size() == 0) chk("q_unexpected_resp", 256'(q_cresp), 256'd0);
      else begin
        e = q_q.pop_front();
        oh = '0; oh[e.client] = 1'b1;
        chk("q_resp", 256'(q_cresp), oh);
        chk("q_maddr", 256'(q_maddr), 256'(e.addr));
        chk("q_rdata", q_crdata, pat(e.addr));
        q_done++;
      end
    end
  end

  // Returns #1 after the edge that captured the target completion.
  task automatic wait_done(input int which, input int target, input string nm);
    int n;
    bit ok;
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      n = (which == 0) ? a_done : (which == 1) ? f_done : q_done;
      if (n >= target) begin ok = 1'b1; break; end
    end
    if (!ok) chk(nm, 256'(n), 256'(target));
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---- reset with both clients requesting ----
    a_read  = 2'b11;
    a_addr  = {32'h0000_2000, 32'h0000_1000};
    a_wdata = {W1, W0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mread", 256'(a_mread), 256'd0);
    chk("rst_cresp", 256'(a_cresp), 256'd0);
    chk("rst_maddr", 256'(a_maddr), 256'd0);
    chk("rst_crdata", a_crdata, 256'd0);
    // ---- round-robin contention: six alternating grants ----
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) a_q.push_back(mk(0, 1'b0, 32'h0000_1000, W0));
      else            a_q.push_back(mk(1, 1'b0, 32'h0000_2000, W1));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_grant_mread", 256'(a_mread), 256'd1);
    chk("first_grant_maddr", 256'(a_maddr), 256'h0000_1000);
    wait_done(0, 6, "rr_contention_timeout");
    a_read = 2'b00;

    // ---- single dcache read, latency 5 ----
    @(posedge clk); #1;
    a_lat = 5;
    a_addr[63:32] = 32'h0000_1240;
    a_read = 2'b10;
    a_q.push_back(mk(1, 1'b0, 32'h0000_1240, W1));
    chk("single_idle_mread", 256'(a_mread), 256'd0);
    @(posedge clk); #1;
    chk("single_lat1_mread", 256'(a_mread), 256'd1);
    chk("single_lat1_maddr", 256'(a_maddr), 256'h0000_1240);
    wait_done(0, 7, "single_read_timeout");
    a_read = 2'b00;

    // ---- dcache write alongside icache read ----
    @(posedge clk); #1;
    a_lat = 3;
    a_addr  = {32'h0000_8000, 32'h0000_4000};
    a_wdata = {WA5, W0};
    a_read  = 2'b01;
    a_write = 2'b10;
    a_q.push_back(mk(0, 1'b0, 32'h0000_4000, W0));
    a_q.push_back(mk(1, 1'b1, 32'h0000_8000, WA5));
    wait_done(0, 8, "wr_fwd_first_timeout");
    a_read = 2'b00;
    wait_done(0, 9, "wr_fwd_second_timeout");
    a_write = 2'b00;

    // ---- fixed priority contention ----
    f_addr = {32'h0000_0300, 32'h0000_0100};
    f_read = 2'b11;
    for (int k = 0; k < 3; k++) f_q.push_back(mk(0, 1'b0, 32'h0000_0100, '0));
    f_q.push_back(mk(1, 1'b0, 32'h0000_0300, '0));
    wait_done(1, 3, "fixed_prio_c0_timeout");
    f_read[0] = 1'b0;
    wait_done(1, 4, "fixed_prio_c1_timeout");
    f_read = 2'b00;

    // ---- 4 clients: reset mid-transaction, stray m_resp ----
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) q_addr[i*32 +: 32] = 32'h0000_1040 + 32'(i) * 32'h1000;
    q_read = 4'b0100;
    @(posedge clk); #1;
    chk("q_busy_mread", 256'(q_mread), 256'd1);
    chk("q_busy_maddr", 256'(q_maddr), 256'h0000_3040);
    @(posedge clk); #1;
    rst_n  = 1'b0;
    q_read = 4'b0000;
    @(negedge clk);
    chk("q_rst_mread", 256'(q_mread), 256'd0);
    chk("q_rst_cresp", 256'(q_cresp), 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #2;
    q_stray = 1'b1;
    @(negedge clk);
    chk("q_stray_cresp", 256'(q_cresp), 256'd0);
    chk("q_stray_mread", 256'(q_mread), 256'd0);
    @(posedge clk); #2;
    q_stray = 1'b0;
    q_auto  = 1'b1;
    for (int i = 0; i < 4; i++) q_q.push_back(mk(i, 1'b0, 32'h0000_1040 + 32'(i) * 32'h1000, '0));
    q_read = 4'b1111;
    wait_done(2, 4, "q_rr_timeout");
    q_read = 4'b0000;

    repeat (5) @(posedge clk);
    chk("a_queue_empty", 256'(a_q.size()), 256'd0);
    chk("f_queue_empty", 256'(f_q.size()), 256'd0);
    chk("q_queue_empty", 256'(q_q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
